rv32_mem_arbiter: RTL and testbench

//  Shares one Avalon-MM pipelined memory port between the core's instruction-fetch master (i*) and data master (d*).

---
 rtl/rv32_mem_arbiter_pkg.sv | 19 +
 rtl/rv32_mem_arb_sel.sv | 40 ++++
 rtl/rv32_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types for the RV32 instruction/data memory arbiter.
// FSM state and bus-owner encodings.
package rv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CMD   = 2'b01,
    ST_RDATA = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } arb_owner_e;

  localparam logic [3:0] BE_ALL = 4'hf;

endpackage

// File: rtl/rv32_mem_arb_sel.sv
// Grant select between fetch and data masters.
// Data has priority; a saturating counter forces a fetch grant.
module rv32_mem_arb_sel #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_arb,
  input  logic                 i_ireq,
  input  logic                 i_dreq,
  output logic                 o_gnt_i,
  output logic                 o_gnt_d,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  localparam logic [CNT_WIDTH-1:0] LIM =
    CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_force;

  assign w_force = (STARVE_LIMIT != 0) &&
                   i_ireq && (r_cnt == LIM);

  assign o_gnt_i = i_arb & i_ireq & (~i_dreq | w_force);
  assign o_gnt_d = i_arb & i_dreq & ~w_force;
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (o_gnt_i) begin
      r_cnt <= '0;
    end else if (o_gnt_d && i_ireq && r_cnt != LIM) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one Avalon-MM pipelined port between fetch and data masters.
// One transaction outstanding; waitrequest-style core-facing slaves.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] iaddress,
  input  logic        iread,
  output logic [31:0] ireaddata,
  output logic        iwaitrequest,
  input  logic [31:0] daddress,
  input  logic        dread,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic        m_waitrequest,
  output logic [1:0]  bus_owner
);

  arb_state_e r_state;
  arb_owner_e r_owner;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_read;
  logic        r_write;

  logic w_dreq, w_gnt_i, w_gnt_d;
  logic w_acc, w_wr_done, w_rd_done;
  logic w_i_cmp, w_d_cmp;
  logic [CNT_WIDTH-1:0] w_cnt;

  assign w_dreq = dread | dwrite;

  rv32_mem_arb_sel #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_sel (
    .clk    (clk),
    .reset_n(reset_n),
    .i_arb  (r_state == ST_IDLE),
    .i_ireq (iread),
    .i_dreq (w_dreq),
    .o_gnt_i(w_gnt_i),
    .o_gnt_d(w_gnt_d),
    .o_cnt  (w_cnt)
  );

  assign w_acc     = (r_state == ST_CMD) & ~m_waitrequest;
  assign w_wr_done = w_acc & r_write;
  assign w_rd_done = m_readdatavalid &
                     ((r_state == ST_RDATA) | (w_acc & r_read));

  // A read only completes if its owner still wants that address.
  assign w_i_cmp = w_rd_done & (r_owner == OWN_I) &
                   iread & (iaddress == r_addr);
  assign w_d_cmp = (w_wr_done & (r_owner == OWN_D)) |
                   (w_rd_done & (r_owner == OWN_D) &
                    dread & ~dwrite & (daddress == r_addr));

  assign iwaitrequest = iread & ~w_i_cmp;
  assign dwaitrequest = w_dreq & ~w_d_cmp;
  assign ireaddata    = m_readdata;
  assign dreaddata    = m_readdata;

  assign m_address    = r_addr;
  assign m_read       = r_read;
  assign m_write      = r_write;
  assign m_writedata  = r_wdata;
  assign m_byteenable = r_be;
  assign bus_owner    = r_owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_d) begin
            r_owner <= OWN_D;
            r_addr  <= daddress;
            r_state <= ST_CMD;
            if (dwrite) begin
              r_write <= 1'b1;
              r_wdata <= dwritedata;
              r_be    <= dbyteenable;
            end else begin
              r_read  <= 1'b1;
              r_wdata <= '0;
              r_be    <= BE_ALL;
            end
          end else if (w_gnt_i) begin
            r_owner <= OWN_I;
            r_addr  <= iaddress;
            r_read  <= 1'b1;
            r_wdata <= '0;
            r_be    <= BE_ALL;
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!m_waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_write || m_readdatavalid) begin
              r_state <= ST_IDLE;
              r_owner <= OWN_NONE;
            end else begin
              r_state <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (m_readdatavalid) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter.
// Hand-computed expectations, one linear stimulus sequence.
module tb_rv32_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] iaddress;
  logic        iread;
  logic [31:0] ireaddata;
  logic        iwaitrequest;
  logic [31:0] daddress;
  logic        dread;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic [31:0] dreaddata;
  logic        dwaitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_waitrequest;
  logic [1:0]  bus_owner;

  int checks = 0;
  int errors = 0;

  rv32_mem_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_WIDTH   (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .iaddress       (iaddress),
    .iread          (iread),
    .ireaddata      (ireaddata),
    .iwaitrequest   (iwaitrequest),
    .daddress       (daddress),
    .dread          (dread),
    .dwrite         (dwrite),
    .dwritedata     (dwritedata),
    .dbyteenable    (dbyteenable),
    .dreaddata      (dreaddata),
    .dwaitrequest   (dwaitrequest),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_waitrequest  (m_waitrequest),
    .bus_owner      (bus_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    iaddress = '0; iread = 1'b1;
    daddress = '0; dread = 1'b0; dwrite = 1'b0;
    dwritedata = '0; dbyteenable = '0;
    m_readdata = '0; m_readdatavalid = 1'b0;
    m_waitrequest = 1'b0;
    #2;
    chk("rst_iwait", 32'(iwaitrequest), 32'd1);
    chk("rst_mread", 32'(m_read), 32'd0);
    chk("rst_mwrite", 32'(m_write), 32'd0);
    chk("rst_maddr", m_address, 32'h0);
    chk("rst_mbe", 32'(m_byteenable), 32'h0);
    chk("rst_owner", 32'(bus_owner), 32'd0);
    iread = 1'b0;
    #1 reset_n = 1'b1;

    // 1: lone fetch
    cyc();
    iread = 1'b1; iaddress = 32'h100;
    #1 chk("t1_wait_T", 32'(iwaitrequest), 32'd1);
    chk("t1_mread_T", 32'(m_read), 32'd0);
    cyc();
    #1 chk("t1_mread_T1", 32'(m_read), 32'd1);
    chk("t1_addr_T1", m_address, 32'h100);
    chk("t1_owner_T1", 32'(bus_owner), 32'd1);
    chk("t1_be_T1", 32'(m_byteenable), 32'hf);
    chk("t1_wait_T1", 32'(iwaitrequest), 32'd1);
    cyc();
    m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
    #1 chk("t1_mread_T2", 32'(m_read), 32'd0);
    chk("t1_wait_T2", 32'(iwaitrequest), 32'd0);
    chk("t1_data_T2", ireaddata, 32'hDEADBEEF);
    cyc();
    iread = 1'b0; m_readdatavalid = 1'b0;
    #1 chk("t1_owner_T3", 32'(bus_owner), 32'd0);

    // 2: simultaneous fetch and store, data first
    cyc();
    iread = 1'b1; iaddress = 32'h104;
    dwrite = 1'b1; daddress = 32'h2000;
    dwritedata = 32'h12345678; dbyteenable = 4'h3;
    #1 chk("t2_dwait_T", 32'(dwaitrequest), 32'd1);
    cyc();
    #1 chk("t2_mwrite", 32'(m_write), 32'd1);
    chk("t2_addr", m_address, 32'h2000);
    chk("t2_be", 32'(m_byteenable), 32'h3);
    chk("t2_wdata", m_writedata, 32'h12345678);
    chk("t2_owner_d", 32'(bus_owner), 32'd2);
    chk("t2_dwait_acc", 32'(dwaitrequest), 32'd0);
    chk("t2_iwait", 32'(iwaitrequest), 32'd1);
    cyc();
    dwrite = 1'b0;
    #1 chk("t2_mwrite_off", 32'(m_write), 32'd0);
    chk("t2_owner_none", 32'(bus_owner), 32'd0);
    cyc();
    #1 chk("t2_iread", 32'(m_read), 32'd1);
    chk("t2_iaddr", m_address, 32'h104);
    chk("t2_owner_i", 32'(bus_owner), 32'd1);
    cyc();
    m_readdatavalid = 1'b1; m_readdata = 32'hA5A5_0104;
    #1 chk("t2_iwait_done", 32'(iwaitrequest), 32'd0);
    chk("t2_idata", ireaddata, 32'hA5A5_0104);
    cyc();
    iread = 1'b0; m_readdatavalid = 1'b0;

    // 3: starvation limit forces a fetch on the 5th grant
    iread = 1'b1; iaddress = 32'h300;
    dwrite = 1'b1; daddress = 32'h400;
    dwritedata = 32'h0000_0400; dbyteenable = 4'hf;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1 chk($sformatf("t3_dgrant%0d", k),
             32'(bus_owner), 32'd2);
      cyc();
    end
    cyc();
    #1 chk("t3_igrant", 32'(bus_owner), 32'd1);
    chk("t3_iaddr", m_address, 32'h300);
    chk("t3_mread", 32'(m_read), 32'd1);
    chk("t3_cnt_clr", 32'(dut.u_sel.r_cnt), 32'd0);
    cyc();
    m_readdatavalid = 1'b1; m_readdata = 32'h0000_0300;
    #1 chk("t3_iwait_done", 32'(iwaitrequest), 32'd0);
    cyc();
    iread = 1'b0; m_readdatavalid = 1'b0;
    #1 chk("t3_owner_idle", 32'(bus_owner), 32'd0);
    cyc();
    #1 chk("t3_next_d", 32'(bus_owner), 32'd2);
    cyc();
    dwrite = 1'b0;

    // 4: fetch redirect while waiting for data
    iread = 1'b1; iaddress = 32'h100;
    cyc();
    #1 chk("t4_addr1", m_address, 32'h100);
    cyc();
    iaddress = 32'h200;
    #1 chk("t4_wait_rd", 32'(iwaitrequest), 32'd1);
    cyc();
    m_readdatavalid = 1'b1; m_readdata = 32'h1111_1111;
    #1 chk("t4_discard", 32'(iwaitrequest), 32'd1);
    cyc();
    m_readdatavalid = 1'b0;
    #1 chk("t4_idle", 32'(bus_owner), 32'd0);
    cyc();
    #1 chk("t4_reread", 32'(m_read), 32'd1);
    chk("t4_addr2", m_address, 32'h200);
    cyc();
    m_readdatavalid = 1'b1; m_readdata = 32'h2222_2222;
    #1 chk("t4_done", 32'(iwaitrequest), 32'd0);
    chk("t4_data", ireaddata, 32'h2222_2222);
    cyc();
    iread = 1'b0; m_readdatavalid = 1'b0;

    // 5: memory stalls the command for 10 cycles
    dwrite = 1'b1; daddress = 32'h3000;
    dwritedata = 32'hCAFEF00D; dbyteenable = 4'hc;
    m_waitrequest = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      #1 chk($sformatf("t5_addr%0d", k), m_address, 32'h3000);
      chk($sformatf("t5_wd%0d", k), m_writedata, 32'hCAFEF00D);
      chk($sformatf("t5_mw%0d", k), 32'(m_write), 32'd1);
      chk($sformatf("t5_dw%0d", k), 32'(dwaitrequest), 32'd1);
    end
    cyc();
    m_waitrequest = 1'b0;
    #1 chk("t5_accept", 32'(dwaitrequest), 32'd0);
    chk("t5_be", 32'(m_byteenable), 32'hc);
    cyc();
    dwrite = 1'b0;
    #1 chk("t5_mw_off", 32'(m_write), 32'd0);

    // 6: reset in RDATA, then late data
    dread = 1'b1; daddress = 32'h500;
    cyc();
    #1 chk("t6_dread", 32'(m_read), 32'd1);
    cyc();
    reset_n = 1'b0;
    #1 chk("t6_rst_mread", 32'(m_read), 32'd0);
    chk("t6_rst_addr", m_address, 32'h0);
    chk("t6_rst_be", 32'(m_byteenable), 32'h0);
    chk("t6_rst_owner", 32'(bus_owner), 32'd0);
    m_readdatavalid = 1'b1; m_readdata = 32'h7777_7777;
    #1 chk("t6_rst_dwait", 32'(dwaitrequest), 32'd1);
    dread = 1'b0; m_readdatavalid = 1'b0;
    #1 reset_n = 1'b1;
    cyc();
    m_readdatavalid = 1'b1;
    #1 chk("t6_late_owner", 32'(bus_owner), 32'd0);
    chk("t6_late_mread", 32'(m_read), 32'd0);
    cyc();
    m_readdatavalid = 1'b0;
    #1 chk("t6_still_idle", 32'(bus_owner), 32'd0);
    chk("t6_no_cmd", 32'(m_read | m_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
